vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) among NUM_REQ independent drawing engines, such as stair/rectangle animators.
- Grants one requester at a time for a whole burst (one rectangle draw or erase), with round-robin fairness, a hold timeout and screen-bounds filtering.
- Sits between the drawing engines and the VGA adapter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_HOLD, 1023, maximum cycles one grant may be held before forced release.
- SCREEN_W, 160, pixels per row; x >= SCREEN_W is off-screen.
- SCREEN_H, 120, pixel rows; y >= SCREEN_H is off-screen.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester burst request, held high for the whole burst.
- last  in  NUM_REQ  marks the final pixel of a burst; qualified by plot_in.
- plot_in  in  NUM_REQ  per-requester pixel-valid strobe.
- x_in  in  8*NUM_REQ  packed x coordinates; requester i uses bits [8i+7:8i].
- y_in  in  7*NUM_REQ  packed y coordinates; requester i uses bits [7i+6:7i].
- colour_in  in  3*NUM_REQ  packed colours; requester i uses bits [3i+2:3i].
- grant  out  NUM_REQ  one-hot grant, registered.
- out_x  out  8  registered x to the VGA adapter.
- out_y  out  7  registered y to the VGA adapter.
- out_colour  out  3  registered colour to the VGA adapter.
- plot  out  1  registered write enable to the VGA adapter.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset: state=IDLE, grant=0, out_x=0, out_y=0, out_colour=0, plot=0, busy=0, timeout=0, rr_ptr=0, hold_cnt=0.
  - A reset mid-burst aborts the burst immediately.
  - The pixel in flight is discarded; plot is 0 on the cycle after reset is sampled.
- FSM states:
  - IDLE: if any req bit is high, select the first i scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ). Set grant=one-hot(i), hold_cnt=0, go to GRANT. With no request, stay in IDLE with grant=0.
  - GRANT (g = granted index): each cycle register out_x/out_y/out_colour from requester g's slice.
    - plot <= plot_in[g] & (x_g < SCREEN_W) & (y_g < SCREEN_H).
    - hold_cnt increments.
  - GRANT exits to RELEASE when any of the following holds:
    - (a) plot_in[g] & last[g]; the last pixel is still registered and output.
    - (b) req[g]==0; the pixel on that cycle is ignored and plot <= 0.
    - (c) hold_cnt == MAX_HOLD-1; the pixel on that cycle is output; timeout pulses high the following cycle.
  - GRANT exit bookkeeping: grant <= 0 and rr_ptr <= (g+1) mod NUM_REQ on the exit edge.
  - RELEASE: plot <= 0, grant=0; go to IDLE unconditionally. Grants are therefore separated by at least 2 idle cycles.
- Latency:
  - Grant rises 1 cycle after req is sampled in IDLE.
  - Pixel to VGA takes 1 cycle: the pixel presented in cycle t appears on out_* / plot in cycle t+1.
- Non-granted requesters:
  - Their plot_in, last and coordinates are ignored and never reach the output.
  - They must hold req until granted.
- Out-of-bounds pixels:
  - out_x/out_y/out_colour still update; only plot is suppressed.
  - Coordinates wrap per 8/7-bit width; there is no clamping.
- When plot=0, out_x/out_y/out_colour hold their last value in IDLE and RELEASE.
- Simultaneous conditions:
  - last and req drop together: treated as (b); pixel not written.
  - last coincides with the timeout cycle: treated as (a); no timeout pulse.
- busy equals (state==GRANT). timeout is high for exactly 1 cycle per forced release.

Test Plan:
- Single requester:
  - Stimulus: req[1]=1, then 40 pixels x=10..49, y=20, colour=3'b101, last on the 40th pixel.
  - Expected: grant=4'b0010 one cycle after req; 40 plot pulses, each 1 cycle after the input, with matching coordinates; grant=0 after the last pixel; rr_ptr=2.
- Round robin:
  - Stimulus: all 4 req high from reset, each burst of 3 pixels ending with last.
  - Expected: grant order 0,1,2,3,0; each pair of grants separated by 2 cycles of grant=0.
- Timeout:
  - Stimulus: MAX_HOLD=8; requester 2 streams pixels without ever asserting last.
  - Expected: exactly 8 plot pulses; grant drops; timeout high for 1 cycle; next grant goes to requester 3 if it is requesting.
- Bounds filtering:
  - Stimulus: granted requester sends (159,119), (160,5), (5,120), (200,127).
  - Expected: plot=1 only for (159,119); out_x/out_y still update to 160/5, 5/120, 200/127.
- Early release and isolation:
  - Stimulus: requester 0 drops req mid-burst while requester 3 toggles plot_in without a grant.
  - Expected: no output from requester 3 while requester 0 is granted; the pixel on requester 0's req-drop cycle is not plotted; requester 3 is granted within 2 cycles of the RELEASE state.
- Reset mid-burst:
  - Stimulus: assert reset for 1 cycle during a GRANT to requester 1.
  - Expected: the next cycle shows grant=0, plot=0, busy=0, out_x=0, out_y=0, out_colour=0; after release, arbitration starts from requester 0.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares the single VGA adapter pixel-write port among NUM_REQ drawing
//   engines. One requester is granted for a whole burst (a rectangle draw or
//   erase). The next requester is picked round-robin. A hold timeout forces a
//   long grant to release. Pixels outside the screen are never written.
//
// Ports
//   clock       system clock
//   reset       synchronous active-high reset
//   req         per-requester burst request, held for the whole burst
//   last        final pixel of a burst (qualified by plot_in)
//   plot_in     per-requester pixel-valid strobe
//   x_in        packed x, requester i at [8i+7:8i]
//   y_in        packed y, requester i at [7i+6:7i]
//   colour_in   packed colour, requester i at [3i+2:3i]
//   grant       registered one-hot grant
//   out_x/out_y/out_colour/plot  registered pixel write to the VGA adapter
//   busy        high while a grant is active
//   timeout     one-cycle pulse after a forced release
module vga_plot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 1023,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     last,
  input  logic [NUM_REQ-1:0]     plot_in,
  input  logic [8*NUM_REQ-1:0]   x_in,
  input  logic [7*NUM_REQ-1:0]   y_in,
  input  logic [3*NUM_REQ-1:0]   colour_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             out_x,
  output logic [6:0]             out_y,
  output logic [2:0]             out_colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   IDX_WRAP  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [8:0]       X_LIM     = 9'(SCREEN_W);
  localparam logic [7:0]       Y_LIM     = 8'(SCREEN_H);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   gidx_r;
  logic [CNT_W-1:0]   hold_cnt_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [7:0]         out_x_r;
  logic [6:0]         out_y_r;
  logic [2:0]         out_colour_r;
  logic               plot_r;
  logic               busy_r;
  logic               timeout_r;

  logic               pick_valid_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [IDX_W:0]     cand_s;

  logic [7:0]         x_g_s;
  logic [6:0]         y_g_s;
  logic [2:0]         c_g_s;
  logic               req_g_s;
  logic               plot_g_s;
  logic               last_g_s;
  logic               in_bounds_s;
  logic               exit_s;
  logic               forced_s;
  logic               px_ok_s;
  logic [IDX_W-1:0]   next_ptr_s;

  assign grant      = grant_r;
  assign out_x      = out_x_r;
  assign out_y      = out_y_r;
  assign out_colour = out_colour_r;
  assign plot       = plot_r;
  assign busy       = busy_r;
  assign timeout    = timeout_r;

  // Requester currently owning the port: its slices and strobes.
  assign x_g_s    = x_in[8*gidx_r +: 8];
  assign y_g_s    = y_in[7*gidx_r +: 7];
  assign c_g_s    = colour_in[3*gidx_r +: 3];
  assign req_g_s  = req[gidx_r];
  assign plot_g_s = plot_in[gidx_r];
  assign last_g_s = last[gidx_r];

  // Round-robin pick: first requesting index scanning from rr_ptr upward.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = {IDX_W{1'b0}};
    cand_s       = {(IDX_W+1){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit keeps rr_ptr+k from wrapping before the modulo.
      cand_s = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
      if (cand_s >= IDX_WRAP) begin
        cand_s = cand_s - IDX_WRAP;
      end else begin
        cand_s = cand_s;
      end
      if (!pick_valid_s && req[cand_s[IDX_W-1:0]]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // Burst exit decode. A dropped request wins over everything (pixel dropped);
  // a last pixel wins over the hold limit, so no timeout is flagged then.
  always_comb begin
    in_bounds_s = ({1'b0, x_g_s} < X_LIM) && ({1'b0, y_g_s} < Y_LIM);
    px_ok_s     = req_g_s && plot_g_s && in_bounds_s;
    forced_s    = req_g_s && !(plot_g_s && last_g_s) && (hold_cnt_r == HOLD_LAST);
    exit_s      = !req_g_s || (plot_g_s && last_g_s) || (hold_cnt_r == HOLD_LAST);
    if (gidx_r == IDX_MAX) begin
      next_ptr_s = {IDX_W{1'b0}};
    end else begin
      next_ptr_s = gidx_r + IDX_W'(1);
    end
  end

  // Arbiter FSM and registered pixel path to the VGA adapter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= {IDX_W{1'b0}};
      gidx_r       <= {IDX_W{1'b0}};
      hold_cnt_r   <= {CNT_W{1'b0}};
      grant_r      <= {NUM_REQ{1'b0}};
      out_x_r      <= 8'd0;
      out_y_r      <= 7'd0;
      out_colour_r <= 3'd0;
      plot_r       <= 1'b0;
      busy_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          plot_r <= 1'b0;
          if (pick_valid_s) begin
            state_r    <= ST_GRANT;
            gidx_r     <= pick_idx_s;
            grant_r    <= ONE_HOT0 << pick_idx_s;
            hold_cnt_r <= {CNT_W{1'b0}};
            busy_r     <= 1'b1;
          end else begin
            grant_r    <= {NUM_REQ{1'b0}};
          end
        end
        ST_GRANT: begin
          // Coordinates follow the owner every cycle; only plot is filtered.
          out_x_r      <= x_g_s;
          out_y_r      <= y_g_s;
          out_colour_r <= c_g_s;
          plot_r       <= px_ok_s;
          hold_cnt_r   <= hold_cnt_r + CNT_W'(1);
          if (exit_s) begin
            state_r   <= ST_RELEASE;
            grant_r   <= {NUM_REQ{1'b0}};
            rr_ptr_r  <= next_ptr_s;
            busy_r    <= 1'b0;
            timeout_r <= forced_s;
          end else begin
            state_r   <= ST_GRANT;
          end
        end
        ST_RELEASE: begin
          plot_r  <= 1'b0;
          grant_r <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          plot_r  <= 1'b0;
          grant_r <= {NUM_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Testbench for vga_plot_arbiter. Two instances share the stimulus: dut uses
// the default hold limit, dut_to uses MAX_HOLD=8 for the timeout scenario.
module tb_vga_plot_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'd0, last = 4'd0, plot_in = 4'd0;
  logic [31:0] x_in = 32'd0;
  logic [27:0] y_in = 28'd0;
  logic [11:0] colour_in = 12'd0;

  logic [3:0] grant, t_grant;
  logic [7:0] out_x, t_out_x;
  logic [6:0] out_y, t_out_y;
  logic [2:0] out_colour, t_out_colour;
  logic       plot, busy, timeout, t_plot, t_busy, t_timeout;

  vga_plot_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .last(last), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .plot(plot),
    .busy(busy), .timeout(timeout)
  );

  vga_plot_arbiter #(.MAX_HOLD(8)) dut_to (
    .clock(clock), .reset(reset), .req(req), .last(last), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(t_grant),
    .out_x(t_out_x), .out_y(t_out_y), .out_colour(t_out_colour), .plot(t_plot),
    .busy(t_busy), .timeout(t_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$], obs_q[$], exp2_q[$], obs2_q[$];
  int checks = 0;
  int errors = 0;

  // Capture every pixel written to the VGA port, stamped with its cycle.
  always @(negedge clock) begin
    if (plot === 1'b1) obs_q.push_back(pix_t'{cyc, out_x, out_y, out_colour});
    if (t_plot === 1'b1) obs2_q.push_back(pix_t'{cyc, t_out_x, t_out_y, t_out_colour});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input int i, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic p, input logic l);
    x_in[8*i +: 8]      = x;
    y_in[7*i +: 7]      = y;
    colour_in[3*i +: 3] = c;
    plot_in[i]          = p;
    last[i]             = l;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'd0; last = 4'd0; plot_in = 4'd0;
    x_in = 32'd0; y_in = 28'd0; colour_in = 12'd0;
    tick();
    reset = 1'b0;
    exp_q.delete(); obs_q.delete(); exp2_q.delete(); obs2_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (grant !== 4'd0) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (plot !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags got plot=%b busy=%b timeout=%b want 0 0 0", plot, busy, timeout); end
    checks++; if ({out_x, out_y, out_colour} !== 18'd0) begin errors++; $display("FAIL reset_pixel got %0d,%0d,%0d want 0,0,0", out_x, out_y, out_colour); end
    checks++; if ({t_grant, t_plot, t_busy, t_timeout} !== 7'd0) begin errors++; $display("FAIL reset_to_dut got %b want 0", {t_grant, t_plot, t_busy, t_timeout}); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    pix_t e, o;
    do_reset();
    req[1] = 1'b1;
    tick();
    checks++; if (grant !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL single_grant got %b busy=%b want 0010 busy=1", grant, busy); end
    for (int i = 0; i < 40; i++) begin
      set_pix(1, 8'(10 + i), 7'd20, 3'b101, 1'b1, (i == 39));
      exp_q.push_back(pix_t'{cyc + 1, 8'(10 + i), 7'd20, 3'b101});
      tick();
    end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release got %b want 0000", grant); end
    req = 4'd0;
    set_pix(1, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL single_pixel missing want x=%0d cyc=%0d", e.x, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || {o.x, o.y, o.c} !== {e.x, e.y, e.c}) begin
          errors++; $display("FAIL single_pixel got cyc=%0d (%0d,%0d,%0d) want cyc=%0d (%0d,%0d,%0d)", o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra got %0d extra pixels want 0", obs_q.size()); end
    // rr_ptr must now be 2: with 0 and 2 both requesting, 2 wins.
    req = 4'b0101;
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_rr_ptr got %b want 0100", grant); end
    req = 4'd0;
    tick(); tick(); tick();
  endtask

  task automatic test_round_robin();
    pix_t e, o;
    int gap;
    int ei;
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      ei = k % 4;
      gap = 0;
      while (grant === 4'd0 && gap < 10) begin
        gap++;
        tick();
      end
      checks++; if (grant !== (4'b0001 << ei)) begin errors++; $display("FAIL rr_order burst %0d got %b want %b", k, grant, 4'b0001 << ei); end
      if (k > 0) begin
        checks++; if (gap != 2) begin errors++; $display("FAIL rr_gap burst %0d got %0d want 2", k, gap); end
      end
      for (int p = 0; p < 3; p++) begin
        set_pix(ei, 8'(40 * ei + p), 7'(10 * ei + p), 3'(ei + p), 1'b1, (p == 2));
        exp_q.push_back(pix_t'{cyc + 1, 8'(40 * ei + p), 7'(10 * ei + p), 3'(ei + p)});
        tick();
      end
      set_pix(ei, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
      if (k == 4) req = 4'd0;
      checks++; if (grant !== 4'd0) begin errors++; $display("FAIL rr_release burst %0d got %b want 0000", k, grant); end
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL rr_pixel missing want x=%0d cyc=%0d", e.x, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || {o.x, o.y, o.c} !== {e.x, e.y, e.c}) begin
          errors++; $display("FAIL rr_pixel got cyc=%0d (%0d,%0d,%0d) want cyc=%0d (%0d,%0d,%0d)", o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rr_extra got %0d extra pixels want 0", obs_q.size()); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    pix_t e, o;
    do_reset();
    req = 4'b1100;
    tick();
    checks++; if (t_grant !== 4'b0100) begin errors++; $display("FAIL to_grant got %b want 0100", t_grant); end
    for (int k = 0; k < 8; k++) begin
      set_pix(2, 8'(k + 1), 7'(k + 2), 3'(k), 1'b1, 1'b0);
      exp2_q.push_back(pix_t'{cyc + 1, 8'(k + 1), 7'(k + 2), 3'(k)});
      tick();
    end
    checks++; if (t_grant !== 4'd0 || t_busy !== 1'b0) begin errors++; $display("FAIL to_drop got grant=%b busy=%b want 0000 0", t_grant, t_busy); end
    checks++; if (t_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", t_timeout); end
    set_pix(2, 8'd50, 7'd50, 3'd7, 1'b1, 1'b0);
    tick();
    checks++; if (t_timeout !== 1'b0 || t_grant !== 4'd0) begin errors++; $display("FAIL to_pulse_width got timeout=%b grant=%b want 0 0000", t_timeout, t_grant); end
    req[2] = 1'b0;
    set_pix(2, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    tick();
    checks++; if (t_grant !== 4'b1000) begin errors++; $display("FAIL to_next_grant got %b want 1000", t_grant); end
    req = 4'd0;
    tick();
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      checks++;
      if (obs2_q.size() == 0) begin
        errors++; $display("FAIL to_pixel missing want x=%0d cyc=%0d", e.x, e.cyc);
      end else begin
        o = obs2_q.pop_front();
        if (o.cyc != e.cyc || {o.x, o.y, o.c} !== {e.x, e.y, e.c}) begin
          errors++; $display("FAIL to_pixel got cyc=%0d (%0d,%0d,%0d) want cyc=%0d (%0d,%0d,%0d)", o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
        end
      end
    end
    checks++; if (obs2_q.size() != 0) begin errors++; $display("FAIL to_extra got %0d extra pixels want 0", obs2_q.size()); end
    tick(); tick();
  endtask

  task automatic test_bounds();
    int bx[4] = '{159, 160, 5, 200};
    int by[4] = '{119, 5, 120, 127};
    logic bp[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    req[1] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      set_pix(1, 8'(bx[k]), 7'(by[k]), 3'(k + 1), 1'b1, (k == 3));
      tick();
      checks++;
      if (out_x !== 8'(bx[k]) || out_y !== 7'(by[k]) || out_colour !== 3'(k + 1) || plot !== bp[k]) begin
        errors++; $display("FAIL bounds_%0d got (%0d,%0d,%0d) plot=%b want (%0d,%0d,%0d) plot=%b", k, out_x, out_y, out_colour, plot, bx[k], by[k], k + 1, bp[k]);
      end
    end
    req = 4'd0;
    set_pix(1, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    tick();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL bounds_count got %0d plots want 1", obs_q.size()); end
    tick(); tick();
  endtask

  task automatic test_early_release();
    pix_t e, o;
    do_reset();
    req = 4'b1001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL early_grant got %b want 0001", grant); end
    for (int k = 0; k < 4; k++) begin
      set_pix(0, 8'(60 + k), 7'(30 + k), 3'd2, 1'b1, 1'b0);
      set_pix(3, 8'(100 + k), 7'(k), 3'd7, ((k % 2) == 1), (k == 1));
      if (k == 3) req[0] = 1'b0;
      else exp_q.push_back(pix_t'{cyc + 1, 8'(60 + k), 7'(30 + k), 3'd2});
      tick();
    end
    checks++; if (grant !== 4'd0) begin errors++; $display("FAIL early_drop got %b want 0000", grant); end
    set_pix(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    set_pix(3, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    tick();
    checks++; if (grant !== 4'd0) begin errors++; $display("FAIL early_idle got %b want 0000", grant); end
    tick();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL early_next got %b want 1000", grant); end
    req = 4'd0;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL early_pixel missing want x=%0d cyc=%0d", e.x, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != e.cyc || {o.x, o.y, o.c} !== {e.x, e.y, e.c}) begin
          errors++; $display("FAIL early_pixel got cyc=%0d (%0d,%0d,%0d) want cyc=%0d (%0d,%0d,%0d)", o.cyc, o.x, o.y, o.c, e.cyc, e.x, e.y, e.c);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL early_isolation got %0d extra pixels want 0", obs_q.size()); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[1] = 1'b1;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rmid_grant got %b want 0010", grant); end
    set_pix(1, 8'd70, 7'd40, 3'd3, 1'b1, 1'b0);
    tick();
    tick();
    checks++; if (plot !== 1'b1 || out_x !== 8'd70) begin errors++; $display("FAIL rmid_pre got plot=%b x=%0d want 1 70", plot, out_x); end
    reset = 1'b1;
    set_pix(1, 8'd71, 7'd41, 3'd4, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    checks++; if (grant !== 4'd0 || plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got grant=%b plot=%b busy=%b want 0000 0 0", grant, plot, busy); end
    checks++; if ({out_x, out_y, out_colour} !== 18'd0) begin errors++; $display("FAIL rmid_pixel got %0d,%0d,%0d want 0,0,0", out_x, out_y, out_colour); end
    req = 4'b0011;
    set_pix(1, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_restart got %b want 0001", grant); end
    req = 4'd0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_bounds();
    test_early_release();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
